// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the ALU it drives.
//
// Contents:
//   - default field widths (opcode, operand, register data, program counter)
//   - opcode encodings understood by the sequencer and the ALU
//   - state_t, the sequencer control state, exported on debugState
package instruction_sequencer_pkg;

    localparam int DEFAULT_OPCODE_WIDTH   = 4;
    localparam int DEFAULT_OPERAND_WIDTH  = 4;
    localparam int DEFAULT_REGISTER_WIDTH = 8;
    localparam int DEFAULT_ADDRESS_WIDTH  = 4;

    // Opcode encodings; codes not listed here execute as NOP.
    localparam int OP_NOP       = 0;
    localparam int OP_LOAD      = 1;
    localparam int OP_ADD       = 2;
    localparam int OP_STORE     = 3;
    localparam int OP_JUMP      = 4;
    localparam int OP_JZ        = 5;
    localparam int OP_OR        = 6;
    localparam int OP_INCREMENT = 7;
    localparam int OP_AND       = 8;
    localparam int OP_HALT      = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        EXECUTE = 2'd2,
        HALTED  = 2'd3
    } state_t;

endpackage

// File: rtl/sequencer_register_file.sv
// General-purpose register file of the instruction sequencer.
//
// 2^ADDR_WIDTH entries of DATA_WIDTH bits. One combinational read port and
// one synchronous write port; all entries clear asynchronously on reset.
//
// Ports:
//   i_clock        clock, rising edge
//   i_reset_n      asynchronous active-low clear
//   i_read_addr    read index
//   o_read_data    register[i_read_addr], combinational
//   i_write_en     write strobe, sampled on the rising edge
//   i_write_addr   write index
//   i_write_data   write data
module sequencer_register_file #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [ADDR_WIDTH-1:0] i_read_addr,
    output logic [DATA_WIDTH-1:0] o_read_data,
    input  logic                  i_write_en,
    input  logic [ADDR_WIDTH-1:0] i_write_addr,
    input  logic [DATA_WIDTH-1:0] i_write_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_write_en) begin
            r_regs[i_write_addr] <= i_write_data;
        end
    end

    assign o_read_data = r_regs[i_read_addr];

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: the control core sitting between instruction memory
// and the ALU. Fetches {opcode, operand} words, latches them, drives the ALU
// operands and writes the ALU result back into the accumulator. Owns the
// program counter, the accumulator and the register file.
//
// Memory handshake: while in FETCH, imemRequest is high and imemAddress (the
// pc) is held stable until a cycle with imemValid=1; the word on imemData is
// taken on that rising edge. imemValid is ignored whenever imemRequest is low,
// and may already be high in the first request cycle.
//
// Ports:
//   clock, resetN        clock (rising edge), asynchronous active-low reset
//   start                one-cycle pulse, starts execution from IDLE/HALTED
//   imemRequest          fetch request
//   imemAddress          fetch address, always equal to the pc
//   imemData, imemValid  instruction word and its valid strobe
//   aluOpCode            opcode of the latched instruction
//   aluAccumulator       current accumulator
//   aluRegisterValue     register[operand of the latched instruction]
//   aluResult            combinational ALU result
//   accumulator          accumulator, for observation
//   busy                 high in FETCH or EXECUTE
//   halted               high in HALTED
//   debugState           current control state
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int OPCODE_WIDTH   = DEFAULT_OPCODE_WIDTH,
    parameter int OPERAND_WIDTH  = DEFAULT_OPERAND_WIDTH,
    parameter int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
    parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                                clock,
    input  logic                                resetN,
    input  logic                                start,
    output logic                                imemRequest,
    output logic [ADDRESS_WIDTH-1:0]            imemAddress,
    input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] imemData,
    input  logic                                imemValid,
    output logic [OPCODE_WIDTH-1:0]             aluOpCode,
    output logic [REGISTER_WIDTH-1:0]           aluAccumulator,
    output logic [REGISTER_WIDTH-1:0]           aluRegisterValue,
    input  logic [REGISTER_WIDTH-1:0]           aluResult,
    output logic [REGISTER_WIDTH-1:0]           accumulator,
    output logic                                busy,
    output logic                                halted,
    output state_t                              debugState
);

    localparam int INSTR_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [ADDRESS_WIDTH-1:0]  r_pc;
    logic [REGISTER_WIDTH-1:0] r_acc;
    logic [INSTR_WIDTH-1:0]    r_instr;

    logic [OPCODE_WIDTH-1:0]   w_opcode;
    logic [OPERAND_WIDTH-1:0]  w_operand;
    logic [REGISTER_WIDTH-1:0] w_reg_value;
    logic [ADDRESS_WIDTH-1:0]  w_jump_target;
    logic                      w_alu_writeback;
    logic                      w_load;
    logic                      w_store;
    logic                      w_take_jump;
    logic                      w_halt;
    logic                      w_reg_write;

    assign w_opcode  = r_instr[INSTR_WIDTH-1:OPERAND_WIDTH];
    assign w_operand = r_instr[OPERAND_WIDTH-1:0];

    // Decode of the latched instruction. JZ looks at the accumulator as it
    // stands before the EXECUTE edge.
    always_comb begin
        w_alu_writeback = 1'b0;
        w_load          = 1'b0;
        w_store         = 1'b0;
        w_take_jump     = 1'b0;
        w_halt          = 1'b0;
        if ((w_opcode == OPCODE_WIDTH'(OP_ADD)) || (w_opcode == OPCODE_WIDTH'(OP_OR)) ||
            (w_opcode == OPCODE_WIDTH'(OP_INCREMENT)) || (w_opcode == OPCODE_WIDTH'(OP_AND))) begin
            w_alu_writeback = 1'b1;
        end
        if (w_opcode == OPCODE_WIDTH'(OP_LOAD)) begin
            w_load = 1'b1;
        end
        if (w_opcode == OPCODE_WIDTH'(OP_STORE)) begin
            w_store = 1'b1;
        end
        if ((w_opcode == OPCODE_WIDTH'(OP_JUMP)) ||
            ((w_opcode == OPCODE_WIDTH'(OP_JZ)) && (r_acc == '0))) begin
            w_take_jump = 1'b1;
        end
        if (w_opcode == OPCODE_WIDTH'(OP_HALT)) begin
            w_halt = 1'b1;
        end
    end

    // Operand zero-extended to pc width; written this way so it also holds
    // when ADDRESS_WIDTH == OPERAND_WIDTH.
    always_comb begin
        w_jump_target                    = '0;
        w_jump_target[OPERAND_WIDTH-1:0] = w_operand;
    end

    assign w_reg_write = (r_state == EXECUTE) && w_store;

    sequencer_register_file #(
        .ADDR_WIDTH (OPERAND_WIDTH),
        .DATA_WIDTH (REGISTER_WIDTH)
    ) u_register_file (
        .i_clock      (clock),
        .i_reset_n    (resetN),
        .i_read_addr  (w_operand),
        .o_read_data  (w_reg_value),
        .i_write_en   (w_reg_write),
        .i_write_addr (w_operand),
        .i_write_data (r_acc)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)     w_next_state = FETCH;
            FETCH:   if (imemValid) w_next_state = EXECUTE;
            EXECUTE: w_next_state = w_halt ? HALTED : FETCH;
            HALTED:  if (start)     w_next_state = FETCH;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_pc    <= '0;
            r_acc   <= '0;
            r_instr <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imemValid) begin
                        r_instr <= imemData;
                        r_pc    <= r_pc + 1'b1;
                    end
                end
                EXECUTE: begin
                    if (w_alu_writeback) begin
                        r_acc <= aluResult;
                    end else if (w_load) begin
                        r_acc <= w_reg_value;
                    end
                    // Overrides the increment applied on the FETCH edge.
                    if (w_take_jump) begin
                        r_pc <= w_jump_target;
                    end
                end
                HALTED: begin
                    if (start) begin
                        r_pc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request is decoded straight from the state register, so an
    // asynchronous reset drops it immediately.
    assign imemRequest      = (r_state == FETCH);
    assign imemAddress      = r_pc;
    assign aluOpCode        = w_opcode;
    assign aluAccumulator   = r_acc;
    assign aluRegisterValue = w_reg_value;
    assign accumulator      = r_acc;
    assign busy             = (r_state == FETCH) || (r_state == EXECUTE);
    assign halted           = (r_state == HALTED);
    assign debugState       = r_state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed testbench for instruction_sequencer with a behavioural ALU and an
// instruction memory responder with a programmable number of wait cycles.
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    logic       clock;
    logic       resetN;
    logic       start;
    logic       imemRequest;
    logic [3:0] imemAddress;
    logic [7:0] imemData;
    logic       imemValid;
    logic [3:0] aluOpCode;
    logic [7:0] aluAccumulator;
    logic [7:0] aluRegisterValue;
    logic [7:0] aluResult;
    logic [7:0] accumulator;
    logic       busy;
    logic       halted;
    state_t     debugState;

    int n_compared;
    int n_mismatched;

    // memory model controls
    logic [7:0] mem [16];
    logic       mem_en;
    int         mem_wait;
    logic       force_valid;
    int         wait_cnt;

    logic [3:0] fetch_addrs[$];
    logic [3:0] exp_q[$];

    instruction_sequencer dut (
        .clock            (clock),
        .resetN           (resetN),
        .start            (start),
        .imemRequest      (imemRequest),
        .imemAddress      (imemAddress),
        .imemData         (imemData),
        .imemValid        (imemValid),
        .aluOpCode        (aluOpCode),
        .aluAccumulator   (aluAccumulator),
        .aluRegisterValue (aluRegisterValue),
        .aluResult        (aluResult),
        .accumulator      (accumulator),
        .busy             (busy),
        .halted           (halted),
        .debugState       (debugState)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural ALU
    always_comb begin
        case (aluOpCode)
            4'd2:    aluResult = aluAccumulator + aluRegisterValue;
            4'd6:    aluResult = aluAccumulator | aluRegisterValue;
            4'd7:    aluResult = aluAccumulator + 8'd1;
            4'd8:    aluResult = aluAccumulator & aluRegisterValue;
            default: aluResult = aluAccumulator;
        endcase
    end

    // instruction memory: answers after mem_wait request cycles
    assign imemData  = mem[imemAddress];
    assign imemValid = force_valid | (mem_en & imemRequest & (wait_cnt == mem_wait));

    always @(posedge clock or negedge resetN) begin
        if (!resetN) wait_cnt <= 0;
        else if (imemRequest && !imemValid) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic do_reset();
        resetN = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    // INC, INC, INC, STORE r2, ADD r2, HALT (operand 2 keeps r2 visible)
    task automatic load_basic_program();
        clear_mem();
        mem[0] = 8'h70; mem[1] = 8'h70; mem[2] = 8'h70;
        mem[3] = 8'h32; mem[4] = 8'h22; mem[5] = 8'hF2;
    endtask

    // Runs until halted or max_cyc cycles, recording accepted fetch addresses.
    task automatic run_prog(input int max_cyc, output int cyc, output bit timeout);
        fetch_addrs.delete();
        cyc     = 0;
        timeout = 1'b0;
        while (!halted) begin
            if (cyc >= max_cyc) begin
                timeout = 1'b1;
                break;
            end
            if (imemRequest && imemValid) fetch_addrs.push_back(imemAddress);
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_compared++;
        if ({imemRequest, imemAddress, aluOpCode, aluAccumulator, aluRegisterValue,
             accumulator, busy, halted} !== 34'd0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got req=%0b addr=%0h op=%0h acc=%0h reg=%0h busy=%0b halted=%0b, expected all 0",
                     imemRequest, imemAddress, aluOpCode, aluAccumulator, aluRegisterValue, busy, halted);
        end
        n_compared++;
        if (debugState !== IDLE) begin
            n_mismatched++;
            $display("FAIL reset_state: got %0d expected %0d", debugState, IDLE);
        end
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic_program();
        int cyc;
        bit timeout;
        load_basic_program();
        mem_en = 1'b1; mem_wait = 0;
        pulse_start();
        run_prog(100, cyc, timeout);
        n_compared++;
        if (timeout !== 1'b0) begin
            n_mismatched++;
            $display("FAIL basic_timeout: halted never rose within %0d cycles", cyc);
        end
        n_compared++;
        if (cyc !== 12) begin
            n_mismatched++;
            $display("FAIL basic_cycles: got %0d expected 12", cyc);
        end
        n_compared++;
        if (accumulator !== 8'd6 || aluAccumulator !== 8'd6) begin
            n_mismatched++;
            $display("FAIL basic_acc: got %0d/%0d expected 6", accumulator, aluAccumulator);
        end
        n_compared++;
        if (aluRegisterValue !== 8'd3) begin
            n_mismatched++;
            $display("FAIL basic_reg2: got %0d expected 3", aluRegisterValue);
        end
        n_compared++;
        if ({aluOpCode, imemAddress, busy, halted, imemRequest} !== {4'hF, 4'd6, 1'b0, 1'b1, 1'b0}) begin
            n_mismatched++;
            $display("FAIL basic_halted_outputs: got op=%0h addr=%0h busy=%0b halted=%0b req=%0b expected op=f addr=6 busy=0 halted=1 req=0",
                     aluOpCode, imemAddress, busy, halted, imemRequest);
        end
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        n_compared++;
        if (fetch_addrs.size() !== exp_q.size()) begin
            n_mismatched++;
            $display("FAIL basic_addr_count: got %0d expected %0d", fetch_addrs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_compared++;
                if (fetch_addrs[i] !== exp_q[i]) begin
                    n_mismatched++;
                    $display("FAIL basic_addr[%0d]: got %0h expected %0h", i, fetch_addrs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_restart();
        int cyc;
        bit timeout;
        // still HALTED with acc=6, r2=3 from the basic program
        pulse_start();
        n_compared++;
        if (imemRequest !== 1'b1 || imemAddress !== 4'd0 || accumulator !== 8'd6) begin
            n_mismatched++;
            $display("FAIL restart_first_fetch: got req=%0b addr=%0h acc=%0d expected req=1 addr=0 acc=6",
                     imemRequest, imemAddress, accumulator);
        end
        run_prog(100, cyc, timeout);
        // 6+3 = 9 stored in r2, then 9+9 = 18
        n_compared++;
        if (timeout !== 1'b0 || accumulator !== 8'd18 || aluRegisterValue !== 8'd9) begin
            n_mismatched++;
            $display("FAIL restart_result: got timeout=%0b acc=%0d r2=%0d expected timeout=0 acc=18 r2=9",
                     timeout, accumulator, aluRegisterValue);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        // two instructions complete, then memory goes silent at address 2
        repeat (3) @(negedge clock);
        mem_en = 1'b0;
        @(negedge clock);
        n_compared++;
        if (imemRequest !== 1'b1 || imemAddress !== 4'd2 || accumulator !== 8'd20) begin
            n_mismatched++;
            $display("FAIL midrun_setup: got req=%0b addr=%0h acc=%0d expected req=1 addr=2 acc=20",
                     imemRequest, imemAddress, accumulator);
        end
        #2 resetN = 1'b0;
        #1;
        n_compared++;
        if ({imemRequest, imemAddress, aluOpCode, aluAccumulator, aluRegisterValue,
             accumulator, busy, halted} !== 34'd0) begin
            n_mismatched++;
            $display("FAIL midrun_async_outputs: got req=%0b addr=%0h op=%0h acc=%0h reg=%0h busy=%0b halted=%0b, expected all 0",
                     imemRequest, imemAddress, aluOpCode, aluAccumulator, aluRegisterValue, busy, halted);
        end
        n_compared++;
        if (debugState !== IDLE) begin
            n_mismatched++;
            $display("FAIL midrun_state: got %0d expected %0d", debugState, IDLE);
        end
        @(negedge clock);
        resetN      = 1'b1;
        mem_en      = 1'b1;
        force_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_compared++;
            if (imemRequest !== 1'b0 || debugState !== IDLE) begin
                n_mismatched++;
                $display("FAIL idle_no_request[%0d]: got req=%0b state=%0d expected req=0 state=0",
                         i, imemRequest, debugState);
            end
        end
        force_valid = 1'b0;
        n_compared++;
        if (accumulator !== 8'd0 || aluOpCode !== 4'd0) begin
            n_mismatched++;
            $display("FAIL idle_late_valid: got acc=%0d op=%0h expected 0/0", accumulator, aluOpCode);
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        bit in_fetch;
        logic [3:0] held_addr;
        do_reset();
        load_basic_program();
        mem_en = 1'b1; mem_wait = 3;
        pulse_start();
        fetch_addrs.delete();
        cyc = 0; in_fetch = 1'b0; held_addr = '0;
        while (!halted && cyc < 200) begin
            if (imemRequest) begin
                if (in_fetch) begin
                    n_compared++;
                    if (imemAddress !== held_addr) begin
                        n_mismatched++;
                        $display("FAIL wait_addr_stable: got %0h expected %0h at cycle %0d", imemAddress, held_addr, cyc);
                    end
                end
                held_addr = imemAddress;
                in_fetch  = 1'b1;
                if (imemValid) begin
                    fetch_addrs.push_back(imemAddress);
                    in_fetch = 1'b0;
                end
            end else if (in_fetch) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL wait_req_stable: request dropped before valid at cycle %0d", cyc);
                in_fetch = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        n_compared++;
        if (cyc !== 30) begin
            n_mismatched++;
            $display("FAIL wait_cycles: got %0d expected 30", cyc);
        end
        n_compared++;
        if (accumulator !== 8'd6 || aluRegisterValue !== 8'd3) begin
            n_mismatched++;
            $display("FAIL wait_result: got acc=%0d r2=%0d expected 6/3", accumulator, aluRegisterValue);
        end
        n_compared++;
        if (fetch_addrs.size() !== 6) begin
            n_mismatched++;
            $display("FAIL wait_addr_count: got %0d expected 6", fetch_addrs.size());
        end
        mem_wait = 0;
    endtask

    task automatic test_jz();
        int cyc;
        bit timeout;
        do_reset();
        clear_mem();
        mem[0]  = 8'h59; // JZ 9, acc=0 -> taken
        mem[9]  = 8'h70; // INC
        mem[10] = 8'h52; // JZ 2, acc=1 -> not taken
        mem[11] = 8'hF0; // HALT
        pulse_start();
        run_prog(100, cyc, timeout);
        exp_q = '{4'd0, 4'd9, 4'd10, 4'd11};
        n_compared++;
        if (timeout !== 1'b0 || fetch_addrs.size() !== exp_q.size()) begin
            n_mismatched++;
            $display("FAIL jz_addr_count: got timeout=%0b count=%0d expected 0/%0d", timeout, fetch_addrs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_compared++;
                if (fetch_addrs[i] !== exp_q[i]) begin
                    n_mismatched++;
                    $display("FAIL jz_addr[%0d]: got %0h expected %0h", i, fetch_addrs[i], exp_q[i]);
                end
            end
        end
        n_compared++;
        if (accumulator !== 8'd1 || cyc !== 8) begin
            n_mismatched++;
            $display("FAIL jz_result: got acc=%0d cycles=%0d expected 1/8", accumulator, cyc);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        bit timeout;
        do_reset();
        clear_mem();
        mem[0]  = 8'h4F; // JUMP 15
        mem[15] = 8'h70; // INC, pc wraps to 0
        pulse_start();
        run_prog(5, cyc, timeout);
        exp_q = '{4'd0, 4'd15, 4'd0};
        n_compared++;
        if (fetch_addrs.size() !== exp_q.size()) begin
            n_mismatched++;
            $display("FAIL wrap_addr_count: got %0d expected %0d", fetch_addrs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_compared++;
                if (fetch_addrs[i] !== exp_q[i]) begin
                    n_mismatched++;
                    $display("FAIL wrap_addr[%0d]: got %0h expected %0h", i, fetch_addrs[i], exp_q[i]);
                end
            end
        end
        n_compared++;
        if (accumulator !== 8'd1) begin
            n_mismatched++;
            $display("FAIL wrap_acc: got %0d expected 1", accumulator);
        end
    endtask

    task automatic test_start_in_fetch();
        int cyc;
        int guard;
        bit timeout;
        do_reset();
        load_basic_program();
        mem_en = 1'b1; mem_wait = 3;
        pulse_start();
        guard = 0;
        while (!(imemRequest && imemAddress == 4'd2) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        n_compared++;
        if (guard >= 50) begin
            n_mismatched++;
            $display("FAIL fetchstart_reach: address 2 fetch not seen within %0d cycles", guard);
        end
        pulse_start();
        n_compared++;
        if (debugState !== FETCH || imemAddress !== 4'd2 || imemRequest !== 1'b1) begin
            n_mismatched++;
            $display("FAIL fetchstart_ignored: got state=%0d addr=%0h req=%0b expected state=1 addr=2 req=1",
                     debugState, imemAddress, imemRequest);
        end
        run_prog(200, cyc, timeout);
        n_compared++;
        if (timeout !== 1'b0 || accumulator !== 8'd6) begin
            n_mismatched++;
            $display("FAIL fetchstart_result: got timeout=%0b acc=%0d expected 0/6", timeout, accumulator);
        end
        mem_wait = 0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        resetN       = 1'b0;
        start        = 1'b0;
        mem_en       = 1'b1;
        mem_wait     = 0;
        force_valid  = 1'b0;
        clear_mem();
        @(negedge clock);
        test_reset();
        test_basic_program();
        test_restart();
        test_reset_mid_run();
        test_wait_states();
        test_jz();
        test_wrap();
        test_start_in_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
